iexecute: RTL and testbench

- Execute stage of the 5-stage RV32I pipeline. It sits directly downstream of idecode and upstream of the memory stage.
- Consumes the ID/EX control and data bundle and performs the ALU operation.
- Resolves branches and jumps combinationally: PCSrcE and PCTargetE go back to ifetch.
- Registers the results into the EX/MEM pipeline register, with stall and flush controls.

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/alu.sv | 37 +++
 rtl/iexecute.sv | 101 ++++++++++
 tb/tb_iexecute.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: ALU operations, result sources and forward selects.
// The optional operand-forwarding path in iexecute is enabled by IEXECUTE_FORWARD_EN.
package pipeline_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_t;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU: result plus zero flag, arithmetic wraps modulo 2^XLEN.
module alu
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  // Operation select; slt compares as signed two's complement.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = XLEN'($signed(a) < $signed(b));
      ALU_SLL: result = a << shamt;
      ALU_SRL: result = a >> shamt;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/iexecute.sv
// Execute stage: operand muxing, ALU, branch/jump resolution and the EX/MEM register.
// Optional macro IEXECUTE_FORWARD_EN adds forwarding inputs for both ALU operands.
module iexecute
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallM,
  input  logic              FlushM,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              JumpE,
  input  logic              BranchE,
  input  logic              ALUSrcE,
  input  logic [1:0]        ResultSrcE,
  input  logic [2:0]        ALUControlE,
  input  logic [REG_AW-1:0] RdE,
  input  logic [XLEN-1:0]   PCE,
  input  logic [XLEN-1:0]   RD1E,
  input  logic [XLEN-1:0]   RD2E,
  input  logic [XLEN-1:0]   ImmExtE,
  input  logic [XLEN-1:0]   PCPlus4E,
`ifdef IEXECUTE_FORWARD_EN
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [XLEN-1:0]   ALUResultFwdM,
  input  logic [XLEN-1:0]   ResultW,
`endif
  output logic              PCSrcE,
  output logic [XLEN-1:0]   PCTargetE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  output logic [REG_AW-1:0] RdM,
  output logic [XLEN-1:0]   ALUResultM,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   PCPlus4M
);

  logic [XLEN-1:0] srcAE;
  logic [XLEN-1:0] rd2FwdE;
  logic [XLEN-1:0] srcBE;
  logic [XLEN-1:0] aluResultE;
  logic            zeroE;

  // Operand selection; the forwarded RD2 also becomes the store data.
  always_comb begin
    srcAE   = RD1E;
    rd2FwdE = RD2E;
`ifdef IEXECUTE_FORWARD_EN
    case (ForwardAE)
      FWD_W:   srcAE = ResultW;
      FWD_M:   srcAE = ALUResultFwdM;
      default: srcAE = RD1E;
    endcase
    case (ForwardBE)
      FWD_W:   rd2FwdE = ResultW;
      FWD_M:   rd2FwdE = ALUResultFwdM;
      default: rd2FwdE = RD2E;
    endcase
`endif
    srcBE = ALUSrcE ? ImmExtE : rd2FwdE;
  end

  alu #(.XLEN(XLEN)) uAlu (
    .a      (srcAE),
    .b      (srcBE),
    .op     (alu_op_t'(ALUControlE)),
    .result (aluResultE),
    .zero   (zeroE)
  );

  // Branch/jump redirect back to fetch, unaffected by stall or flush.
  assign PCSrcE    = (BranchE & zeroE) | JumpE;
  assign PCTargetE = PCE + ImmExtE;

  // EX/MEM register: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset || FlushM) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      RdM        <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else if (!StallM) begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RdM        <= RdE;
      ALUResultM <= aluResultE;
      WriteDataM <= rd2FwdE;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_iexecute.sv
// Directed self-checking bench for iexecute; forwarding test runs only with IEXECUTE_FORWARD_EN.
module tb_iexecute;

  logic        clk = 1'b0;
  logic        reset, StallM, FlushM;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [4:0]  RdE;
  logic [31:0] PCE, RD1E, RD2E, ImmExtE, PCPlus4E;
`ifdef IEXECUTE_FORWARD_EN
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ALUResultFwdM, ResultW;
`endif
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  int checks = 0;
  int errors = 0;

  iexecute dut (
    .clk(clk), .reset(reset), .StallM(StallM), .FlushM(FlushM),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .RdE(RdE),
    .PCE(PCE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
`ifdef IEXECUTE_FORWARD_EN
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUResultFwdM(ALUResultFwdM), .ResultW(ResultW),
`endif
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .RdM(RdM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b0; StallM = 1'b0; FlushM = 1'b0;
    RegWriteE = 1'b0; MemWriteE = 1'b0; JumpE = 1'b0; BranchE = 1'b0; ALUSrcE = 1'b0;
    ResultSrcE = 2'b00; ALUControlE = 3'b000; RdE = '0;
    PCE = '0; RD1E = '0; RD2E = '0; ImmExtE = '0; PCPlus4E = '0;
`ifdef IEXECUTE_FORWARD_EN
    ForwardAE = 2'b00; ForwardBE = 2'b00; ALUResultFwdM = '0; ResultW = '0;
`endif
  endtask

  task automatic test_reset();
    clear_inputs();
    RegWriteE = 1'b1; MemWriteE = 1'b1; RD1E = 32'h11; RD2E = 32'h22; RdE = 5'd9;
    ResultSrcE = 2'b10; PCPlus4E = 32'h44;
    reset = 1'b1;
    step();
    checks++;
    if ({RegWriteM, MemWriteM, ResultSrcM, RdM, ALUResultM, WriteDataM, PCPlus4M} !== '0) begin
      errors++;
      $display("FAIL reset_clear: got RegW=%0b MemW=%0b Rsrc=%0d Rd=%0d Alu=%h Wd=%h Pc4=%h, want all 0",
               RegWriteM, MemWriteM, ResultSrcM, RdM, ALUResultM, WriteDataM, PCPlus4M);
    end
    reset = 1'b0;
  endtask

  task automatic test_add();
    clear_inputs();
    RD1E = 32'd5; RD2E = 32'd7; ALUControlE = 3'b000; RdE = 5'd3; RegWriteE = 1'b1;
    step();
    checks++;
    if (ALUResultM !== 32'd12) begin errors++; $display("FAIL add_result: got %h want %h", ALUResultM, 32'd12); end
    checks++;
    if (RdM !== 5'd3 || RegWriteM !== 1'b1) begin
      errors++; $display("FAIL add_ctrl: got Rd=%0d RegW=%0b want Rd=3 RegW=1", RdM, RegWriteM);
    end
    checks++;
    if (WriteDataM !== 32'd7) begin errors++; $display("FAIL add_wdata: got %h want 7", WriteDataM); end
    // x0 destination passes through unchanged
    RdE = 5'd0;
    step();
    checks++;
    if (RdM !== 5'd0 || RegWriteM !== 1'b1) begin
      errors++; $display("FAIL x0_passthru: got Rd=%0d RegW=%0b want Rd=0 RegW=1", RdM, RegWriteM);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    RD1E = 32'h10; RD2E = 32'h10; ALUControlE = 3'b001; BranchE = 1'b1;
    PCE = 32'h40; ImmExtE = 32'hFFFF_FFF8;
    #1;
    checks++;
    if (PCSrcE !== 1'b1) begin errors++; $display("FAIL beq_taken: got %0b want 1", PCSrcE); end
    checks++;
    if (PCTargetE !== 32'h38) begin errors++; $display("FAIL beq_target: got %h want 00000038", PCTargetE); end
    RD2E = 32'h11;
    #1;
    checks++;
    if (PCSrcE !== 1'b0) begin errors++; $display("FAIL beq_not_taken: got %0b want 0", PCSrcE); end
    // zero from a wrapped add still takes the branch; target wraps too
    ALUControlE = 3'b000; RD1E = 32'hFFFF_FFFF; RD2E = 32'd1;
    PCE = 32'hFFFF_FFFC; ImmExtE = 32'd8;
    #1;
    checks++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h4) begin
      errors++; $display("FAIL wrap_branch: got PCSrc=%0b tgt=%h want 1 00000004", PCSrcE, PCTargetE);
    end
    step();
    checks++;
    if (ALUResultM !== 32'h0) begin errors++; $display("FAIL add_wrap: got %h want 0", ALUResultM); end
  endtask

  task automatic test_jal();
    clear_inputs();
    JumpE = 1'b1; ResultSrcE = 2'b10; PCPlus4E = 32'h104; RD1E = 32'h3; RD2E = 32'h5;
    #1;
    checks++;
    if (PCSrcE !== 1'b1) begin errors++; $display("FAIL jal_pcsrc: got %0b want 1", PCSrcE); end
    step();
    checks++;
    if (PCPlus4M !== 32'h104 || ResultSrcM !== 2'b10) begin
      errors++; $display("FAIL jal_regs: got Pc4=%h Rsrc=%0d want 00000104 2", PCPlus4M, ResultSrcM);
    end
  endtask

  task automatic test_logic_shift();
    logic [2:0]  ops  [5] = '{3'b010, 3'b011, 3'b100, 3'b110, 3'b111};
    logic [31:0] aval [5] = '{32'hF0F0, 32'hF0F0, 32'hF0F0, 32'h1, 32'h8000_0000};
    logic [31:0] bval [5] = '{32'hFF00, 32'hFF00, 32'hFF00, 32'h21, 32'h3F};
    logic [31:0] want [5] = '{32'hF000, 32'hFFF0, 32'h0FF0, 32'h2, 32'h1};
    clear_inputs();
    ALUSrcE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ALUControlE = ops[i]; RD1E = aval[i]; ImmExtE = bval[i];
      step();
      checks++;
      if (ALUResultM !== want[i]) begin
        errors++; $display("FAIL alu_op%0d: got %h want %h", ops[i], ALUResultM, want[i]);
      end
    end
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    RD1E = 32'h20; RegWriteE = 1'b1; MemWriteE = 1'b1;
    step();
    checks++;
    if (ALUResultM !== 32'h20) begin errors++; $display("FAIL stall_load: got %h want 00000020", ALUResultM); end
    StallM = 1'b1; RD1E = 32'h55; RD2E = 32'h1; JumpE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (ALUResultM !== 32'h20 || RegWriteM !== 1'b1 || MemWriteM !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d: got Alu=%h RegW=%0b MemW=%0b want 00000020 1 1",
                           i, ALUResultM, RegWriteM, MemWriteM);
      end
    end
    checks++;
    if (PCSrcE !== 1'b1) begin errors++; $display("FAIL stall_pcsrc: got %0b want 1", PCSrcE); end
    FlushM = 1'b1;
    step();
    checks++;
    if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0 || ALUResultM !== 32'h0 || WriteDataM !== 32'h0) begin
      errors++; $display("FAIL flush_over_stall: got RegW=%0b MemW=%0b Alu=%h Wd=%h want 0 0 0 0",
                         RegWriteM, MemWriteM, ALUResultM, WriteDataM);
    end
  endtask

  task automatic test_store_slt();
    clear_inputs();
    MemWriteE = 1'b1; ALUSrcE = 1'b1; RD1E = 32'h100; ImmExtE = 32'd8; RD2E = 32'hDEAD_BEEF;
    step();
    checks++;
    if (ALUResultM !== 32'h108 || WriteDataM !== 32'hDEAD_BEEF || MemWriteM !== 1'b1) begin
      errors++; $display("FAIL store: got Alu=%h Wd=%h MemW=%0b want 00000108 deadbeef 1",
                         ALUResultM, WriteDataM, MemWriteM);
    end
    clear_inputs();
    ALUControlE = 3'b101; RD1E = 32'hFFFF_FFFF; RD2E = 32'd1;
    step();
    checks++;
    if (ALUResultM !== 32'd1) begin errors++; $display("FAIL slt_neg: got %h want 1", ALUResultM); end
    RD1E = 32'd1; RD2E = 32'hFFFF_FFFF;
    step();
    checks++;
    if (ALUResultM !== 32'd0) begin errors++; $display("FAIL slt_pos: got %h want 0", ALUResultM); end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    RD1E = 32'h77; RegWriteE = 1'b1;
    step();
    reset = 1'b1; JumpE = 1'b1;
    #1;
    checks++;
    if (PCSrcE !== 1'b1) begin errors++; $display("FAIL reset_pcsrc: got %0b want 1", PCSrcE); end
    step();
    checks++;
    if (ALUResultM !== 32'h0 || RegWriteM !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got Alu=%h RegW=%0b want 0 0", ALUResultM, RegWriteM);
    end
    reset = 1'b0;
  endtask

`ifdef IEXECUTE_FORWARD_EN
  task automatic test_forward();
    clear_inputs();
    ForwardAE = 2'b10; ALUResultFwdM = 32'd9; ForwardBE = 2'b01; ResultW = 32'd4;
    ALUControlE = 3'b001; RD1E = 32'd100; RD2E = 32'd50;
    step();
    checks++;
    if (ALUResultM !== 32'd5 || WriteDataM !== 32'd4) begin
      errors++; $display("FAIL fwd_sub: got Alu=%h Wd=%h want 5 4", ALUResultM, WriteDataM);
    end
    ForwardAE = 2'b11; ForwardBE = 2'b11;
    step();
    checks++;
    if (ALUResultM !== 32'd50 || WriteDataM !== 32'd50) begin
      errors++; $display("FAIL fwd_11: got Alu=%h Wd=%h want 00000032 00000032", ALUResultM, WriteDataM);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_add();
    test_branch();
    test_jal();
    test_logic_shift();
    test_stall_flush();
    test_store_slt();
    test_reset_mid();
`ifdef IEXECUTE_FORWARD_EN
    test_forward();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
